// File: rtl/pmod_keypad_scanner.sv
// pmod_keypad_scanner
//   Column-strobe scanner for a 4x4 hex keypad on a Pmod header. One column is
//   driven low at a time, the active-low rows are synchronised and captured at
//   the end of each column window, and a full four-column snapshot is
//   classified as no key, exactly one key, or several keys. A debounce FSM
//   accepts a change only after DEBOUNCE_SCANS identical scans and emits a
//   single key_valid pulse for each newly accepted key.
module pmod_keypad_scanner #(
  parameter int SCAN_DIV       = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [3:0] Col,
  input  logic [3:0] Row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  // Counter widths; a single-cycle window would still need one bit.
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_FULL = DEB_W'(DEBOUNCE_SCANS);
  localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);

  // Candidate / pending encoding: {is_key, code}; 5'b0_0000 means "no key".
  localparam logic [4:0] CAND_NONE = 5'b0_0000;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESSED = 1'b1
  } state_t;

  // Hex value printed on the key at snapshot position {col, row}.
  function automatic logic [3:0] key_of(input logic [3:0] pos);
    logic [3:0] code;
    case (pos)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h4;
      4'd2:    code = 4'h7;
      4'd3:    code = 4'h0;
      4'd4:    code = 4'h2;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h8;
      4'd7:    code = 4'hF;
      4'd8:    code = 4'h3;
      4'd9:    code = 4'h6;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hE;
      4'd12:   code = 4'hA;
      4'd13:   code = 4'hB;
      4'd14:   code = 4'hC;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // ---------------------------------------------------------------------------
  // Row synchroniser
  // ---------------------------------------------------------------------------
  logic [3:0] row_sync1_reg;
  logic [3:0] row_sync2_reg;

  // Two-flop synchroniser for the asynchronous row returns (idle = all high).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      row_sync1_reg <= 4'b1111;
      row_sync2_reg <= 4'b1111;
    end else begin
      row_sync1_reg <= Row;
      row_sync2_reg <= row_sync1_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Column scan
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       col_idx_reg;
  logic [3:0]       col_reg;
  logic             window_end;
  logic             scan_end;

  assign window_end = (cnt_reg == CNT_LAST);
  // The column-3 capture completes a full scan of the keypad.
  assign scan_end   = window_end && (col_idx_reg == 2'd3);

  // Window counter and column strobe; the low bit rotates 0 -> 1 -> 2 -> 3.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_reg     <= '0;
      col_idx_reg <= 2'd0;
      col_reg     <= 4'b1110;
    end else if (window_end) begin
      cnt_reg     <= '0;
      col_idx_reg <= col_idx_reg + 2'd1;
      col_reg     <= {col_reg[2:0], col_reg[3]};
    end else begin
      cnt_reg     <= cnt_reg + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Snapshot capture
  // ---------------------------------------------------------------------------
  logic [15:0] snap_reg;
  logic [3:0]  cap_en;
  logic [15:0] scan_bits;

  // Per-column capture strobes, plus the completed scan image. Column 3 is
  // taken straight from the synchroniser because it is being captured in the
  // very cycle the scan is evaluated.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign cap_en[gi] = window_end && (col_idx_reg == 2'(gi));
      if (gi == 3) begin : g_live
        assign scan_bits[gi*4 +: 4] = ~row_sync2_reg;
      end else begin : g_held
        assign scan_bits[gi*4 +: 4] = snap_reg[gi*4 +: 4];
      end
    end
  endgenerate

  // Capture the pressed-row pattern (active-high) at the end of each window.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      snap_reg <= '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (cap_en[c]) begin
          snap_reg[c*4 +: 4] <= ~row_sync2_reg;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan classification
  // ---------------------------------------------------------------------------
  logic [4:0] pop_count;
  logic [3:0] hit_pos;
  logic       cand_multi;
  logic       cand_key;
  logic [4:0] cand;

  // Count pressed positions; with exactly one hit, hit_pos is its location.
  always_comb begin
    pop_count = '0;
    hit_pos   = '0;
    for (int i = 0; i < 16; i++) begin
      if (scan_bits[i]) begin
        pop_count = pop_count + 5'd1;
        hit_pos   = 4'(i);
      end
    end
  end

  assign cand_multi = (pop_count >= 5'd2);
  assign cand_key   = (pop_count == 5'd1);
  assign cand       = cand_key ? {1'b1, key_of(hit_pos)} : CAND_NONE;

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  state_t           state_reg;
  logic [4:0]       pend_reg;
  logic [4:0]       pend_next;
  logic [DEB_W-1:0] deb_cnt_reg;
  logic [DEB_W-1:0] deb_cnt_next;
  logic             key_valid_reg;
  logic [3:0]       key_code_reg;
  logic             key_held_reg;
  logic             differs;
  logic             accept;

  // Track the pending candidate and how many consecutive scans agreed on it.
  // A multi-key scan only breaks the run; the pending value is kept.
  always_comb begin
    pend_next    = pend_reg;
    deb_cnt_next = deb_cnt_reg;
    if (scan_end) begin
      if (cand_multi) begin
        deb_cnt_next = '0;
      end else if (cand == pend_reg) begin
        deb_cnt_next = (deb_cnt_reg == DEB_FULL) ? DEB_FULL : deb_cnt_reg + DEB_ONE;
      end else begin
        pend_next    = cand;
        deb_cnt_next = DEB_ONE;
      end
    end
  end

  // While PRESSED the stable key is the one reported on key_code.
  assign differs = (pend_next[4] != (state_reg == PRESSED)) ||
                   (pend_next[4] && (pend_next[3:0] != key_code_reg));
  assign accept  = scan_end && !cand_multi && (deb_cnt_next == DEB_FULL) && differs;

  // Debounce FSM with registered outputs; key_valid is a one-cycle strobe.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= IDLE;
      pend_reg      <= CAND_NONE;
      deb_cnt_reg   <= '0;
      key_valid_reg <= 1'b0;
      key_code_reg  <= 4'h0;
      key_held_reg  <= 1'b0;
    end else begin
      pend_reg      <= pend_next;
      deb_cnt_reg   <= deb_cnt_next;
      key_valid_reg <= 1'b0;
      if (accept) begin
        if (pend_next[4]) begin
          state_reg     <= PRESSED;
          key_valid_reg <= 1'b1;
          key_code_reg  <= pend_next[3:0];
          key_held_reg  <= 1'b1;
        end else begin
          state_reg     <= IDLE;
          key_held_reg  <= 1'b0;
        end
      end
    end
  end

  assign Col       = col_reg;
  assign key_valid = key_valid_reg;
  assign key_code  = key_code_reg;
  assign key_held  = key_held_reg;

endmodule

// File: tb/tb_pmod_keypad_scanner.sv
// Testbench for pmod_keypad_scanner: a keypad model closes row/column contacts
// for the keys the stimulus presses, and expectations come from the key legend
// and the accept rules (one pulse per new key, bounded latency, no repeats).
module tb_pmod_keypad_scanner;

  localparam int SD  = 4;
  localparam int DS  = 3;
  localparam int LAT = (DS + 1) * 4 * SD + 3;

  logic       Clk   = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Col;
  logic [3:0] Row;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  logic [15:0] keys = '0;  // bit c*4+r = key at column c, row r is closed

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int first_pulse_cyc = 0;
  logic [3:0] codes[$];

  // Legend printed on the keypad, [column][row].
  logic [3:0] kmap [4][4] = '{'{4'h1, 4'h4, 4'h7, 4'h0},
                              '{4'h2, 4'h5, 4'h8, 4'hF},
                              '{4'h3, 4'h6, 4'h9, 4'hE},
                              '{4'hA, 4'hB, 4'hC, 4'hD}};

  always #5 Clk = ~Clk;

  pmod_keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .Clk(Clk), .Reset(Reset), .Col(Col), .Row(Row),
    .key_valid(key_valid), .key_code(key_code), .key_held(key_held)
  );

  // Passive matrix: a closed key pulls its row low while its column is driven low.
  always_comb begin
    Row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4 + r] && !Col[c]) Row[r] = 1'b0;
  end

  function automatic logic [15:0] key_bit(input logic [3:0] code);
    logic [15:0] b;
    b = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (kmap[c][r] == code) b[c*4 + r] = 1'b1;
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clk);
      cyc++;
      if (key_valid === 1'b1) begin
        pulse_cnt++;
        codes.push_back(key_code);
        if (pulse_cnt == 1) first_pulse_cyc = cyc;
      end
    end
  endtask

  task automatic clear_pulses();
    pulse_cnt = 0;
    codes.delete();
  endtask

  task automatic wait_pulses(input int n, input int bound, output int waited);
    waited = 0;
    while (pulse_cnt < n && waited < bound) begin
      tick(1);
      waited++;
    end
  endtask

  function automatic logic [31:0] code_at(input int i);
    return (codes.size() > i) ? 32'(codes[i]) : 32'h1F;
  endfunction

  initial begin
    int w;
    int start;
    int hold;
    logic [3:0] k;
    logic [3:0] k2;
    logic [3:0] exp_col;

    // 1: reset values and column rotation
    Reset = 1'b1;
    tick(3);
    chk("rst_col", Col, 4'b1110);
    chk("rst_valid", key_valid, 1'b0);
    chk("rst_code", key_code, 4'h0);
    chk("rst_held", key_held, 1'b0);
    Reset = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      exp_col = ~(4'b0001 << ((i / SD) % 4));
      chk("col_seq", Col, exp_col);
    end
    $display("step1 reset/column rotation done cyc=%0d", cyc);

    // 2: random single keys held then released
    for (int t = 0; t < 5; t++) begin
      k = 4'($urandom_range(0, 15));
      clear_pulses();
      keys  = key_bit(k);
      start = cyc;
      wait_pulses(1, LAT + 5, w);
      chk("t2_latency", (pulse_cnt >= 1) && (first_pulse_cyc - start <= LAT), 1);
      hold = $urandom_range(150, 200);
      tick(hold - w);
      chk("t2_pulses", pulse_cnt, 1);
      chk("t2_code", code_at(0), k);
      chk("t2_held", key_held, 1'b1);
      keys = '0;
      clear_pulses();
      w = 0;
      while (key_held !== 1'b0 && w < LAT + 5) begin
        tick(1);
        w++;
      end
      chk("t2_release_lat", w <= LAT, 1);
      tick(100 - w);
      chk("t2_release_nopulse", pulse_cnt, 0);
      chk("t2_code_retained", key_code, k);
      $display("step2 key=%h pulses=1 released cyc=%0d", k, cyc);
    end

    // 3: chattering 'E' then solid
    clear_pulses();
    for (int i = 0; i < 8; i++) begin
      keys = (i % 2 == 0) ? key_bit(4'hE) : '0;
      tick(10);
    end
    keys = key_bit(4'hE);
    tick(120);
    chk("t3_pulses", pulse_cnt, 1);
    chk("t3_code", code_at(0), 4'hE);
    chk("t3_held", key_held, 1'b1);
    keys = '0;
    clear_pulses();
    tick(100);
    chk("t3_release_held", key_held, 1'b0);
    chk("t3_release_nopulse", pulse_cnt, 0);
    $display("step3 chatter key=E done cyc=%0d", cyc);

    // 4: two keys together from IDLE never produce an accept
    for (int t = 0; t < 3; t++) begin
      if (t == 0) begin
        k = 4'h1; k2 = 4'h2;
      end else begin
        k  = 4'($urandom_range(0, 15));
        k2 = 4'((32'(k) + $urandom_range(1, 15)) % 16);
      end
      clear_pulses();
      keys = key_bit(k) | key_bit(k2);
      tick(200);
      chk("t4_nopulse", pulse_cnt, 0);
      chk("t4_held", key_held, 1'b0);
      keys = '0;
      tick(80);
      chk("t4_release_nopulse", pulse_cnt, 0);
      $display("step4 keys=%h+%h no accept cyc=%0d", k, k2, cyc);
    end

    // 5: reset while a key is held, then re-accept
    for (int t = 0; t < 2; t++) begin
      k = (t == 0) ? 4'hA : 4'($urandom_range(0, 15));
      clear_pulses();
      keys = key_bit(k);
      wait_pulses(1, LAT + 5, w);
      chk("t5_first_pulse", pulse_cnt, 1);
      chk("t5_first_code", code_at(0), k);
      tick($urandom_range(1, 21));
      Reset = 1'b1;
      tick(1);
      chk("t5_rst_col", Col, 4'b1110);
      chk("t5_rst_valid", key_valid, 1'b0);
      chk("t5_rst_code", key_code, 4'h0);
      chk("t5_rst_held", key_held, 1'b0);
      Reset = 1'b0;
      clear_pulses();
      start = cyc;
      wait_pulses(1, LAT + 5, w);
      chk("t5_relatency", (pulse_cnt == 1) && (first_pulse_cyc - start <= LAT), 1);
      chk("t5_second_code", code_at(0), k);
      keys = '0;
      tick(100);
      chk("t5_release_held", key_held, 1'b0);
      $display("step5 key=%h reset-reaccept cyc=%0d", k, cyc);
    end

    // 6: direct switch between two keys gives two pulses
    for (int t = 0; t < 3; t++) begin
      if (t == 0) begin
        k = 4'h7; k2 = 4'h9;
      end else begin
        k  = 4'($urandom_range(0, 15));
        k2 = 4'((32'(k) + $urandom_range(1, 15)) % 16);
      end
      clear_pulses();
      keys = key_bit(k);
      tick(100);
      keys = key_bit(k2);
      tick(100);
      chk("t6_pulses", pulse_cnt, 2);
      chk("t6_code1", code_at(0), k);
      chk("t6_code2", code_at(1), k2);
      chk("t6_held", key_held, 1'b1);
      keys = '0;
      tick(100);
      chk("t6_release_held", key_held, 1'b0);
      $display("step6 keys=%h->%h pulses=%0d cyc=%0d", k, k2, pulse_cnt, cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
